// File: rtl/dmem_unit_if.sv
// MEM-stage to data-memory bus: request, address, store data, byte mask and completion status.
// Latency: none (wires only).
// Backpressure: stallM from the memory holds the requester until doneM.
interface dmem_unit_if #(
    parameter int XLEN = 32
);
    logic            memreadM;
    logic            memwriteM;
    logic [XLEN-1:0] aluoutM;
    logic [XLEN-1:0] writedataM;
    logic [3:0]      ampM;
    logic [XLEN-1:0] readdataM;
    logic            stallM;
    logic            doneM;
    logic            errM;

    modport master (
        output memreadM, memwriteM, aluoutM, writedataM, ampM,
        input  readdataM, stallM, doneM, errM
    );

    modport slave (
        input  memreadM, memwriteM, aluoutM, writedataM, ampM,
        output readdataM, stallM, doneM, errM
    );
endinterface

// File: rtl/dmem_unit.sv
// Multi-cycle data memory behind the MEM stage: raw word read, byte-masked store, sticky range error.
// Latency: WAIT_CYCLES+1 cycles per access; read data and doneM are combinational in the completing cycle.
// Backpressure: stallM stays high until the access completes; request inputs must be held while stalled.
module dmem_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic        clk,
    input logic        reset,
    dmem_unit_if.slave bus
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam int         LANES  = XLEN / 8;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  errQ;
    logic [XLEN-1:0]       mem [DEPTH];

    logic                  req;
    logic                  outOfRange;
    logic                  complete;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] index;
    logic [1:0]            unusedByteOffset;

    assign req              = bus.memreadM | bus.memwriteM;
    assign index            = bus.aluoutM[ADDR_WIDTH+1:2];
    assign unusedByteOffset = bus.aluoutM[1:0];
    assign outOfRange       = |bus.aluoutM[XLEN-1:ADDR_WIDTH+2];

    // Gating with reset keeps every status output quiet while reset is held, even with req high.
    assign complete = reset && req &&
                      ((state == IDLE && WAIT_CYCLES == 0) || (state == WAIT && cnt == WAIT_N));
    assign commit   = complete && bus.memwriteM && !outOfRange;

    assign bus.stallM    = reset && req && !complete;
    assign bus.doneM     = complete;
    assign bus.readdataM = (complete && !outOfRange) ? mem[index] : '0;
    assign bus.errM      = errQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            errQ  <= 1'b0;
        end else begin
            if (complete && outOfRange) begin
                errQ <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req && WAIT_CYCLES != 0) begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    // A dropped request abandons the access with no write.
                    if (!req || cnt == WAIT_N) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Storage is never reset; only the enabled byte lanes are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (commit && bus.ampM[i]) begin
                mem[index][8*i +: 8] <= bus.writedataM[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: directed scenarios on a 2-wait-state and a zero-wait instance, plus randomized traffic vs a word-array model.
module tb_dmem_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mdl [1024];

    always #5 clk = ~clk;

    dmem_unit_if #(.XLEN(32)) bus2 ();
    dmem_unit_if #(.XLEN(32)) bus0 ();

    dmem_unit #(.XLEN(32), .ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_unit #(.XLEN(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle2();
        bus2.memreadM   = 1'b0;
        bus2.memwriteM  = 1'b0;
        bus2.aluoutM    = '0;
        bus2.writedataM = '0;
        bus2.ampM       = '0;
        @(posedge clk); #1;
    endtask

    // Drives one request on the 2-wait instance and observes it until doneM (bounded).
    // nStall counts stalled cycles; a cycle that neither stalls nor completes adds 100.
    task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rdata, output int nStall,
                       output bit timedOut, output logic errAtDone);
        bus2.memreadM   = rd;
        bus2.memwriteM  = wr;
        bus2.aluoutM    = a;
        bus2.writedataM = d;
        bus2.ampM       = m;
        rdata     = '0;
        nStall    = 0;
        timedOut  = 1'b1;
        errAtDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus2.doneM === 1'b1) begin
                rdata     = bus2.readdataM;
                errAtDone = bus2.errM;
                if (bus2.stallM !== 1'b0) nStall += 100;
                timedOut = 1'b0;
            end else if (bus2.stallM === 1'b1) begin
                nStall++;
            end else begin
                nStall += 100;
            end
            @(posedge clk); #1;
            if (!timedOut) break;
        end
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus2.memreadM   = 1'b1;
        bus2.memwriteM  = 1'b1;
        bus2.aluoutM    = 32'h10;
        bus2.writedataM = 32'h1;
        bus2.ampM       = 4'hF;
        bus0.memreadM   = 1'b1;
        bus0.memwriteM  = 1'b0;
        bus0.aluoutM    = 32'h10;
        bus0.writedataM = '0;
        bus0.ampM       = '0;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus2.stallM !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus2.stallM); end
        total++; if (bus2.doneM !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus2.doneM); end
        total++; if (bus2.readdataM !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus2.readdataM); end
        total++; if (bus2.errM !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus2.errM); end
        total++; if (bus0.doneM !== 1'b0) begin bad++; $display("FAIL reset_done0 got=%b exp=0", bus0.doneM); end
        total++; if (bus0.readdataM !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", bus0.readdataM); end
        bus0.memreadM = 1'b0;
        idle2();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus2.stallM !== 1'b0 || bus2.doneM !== 1'b0 || bus2.readdataM !== 32'h0) begin
            bad++; $display("FAIL idle_outputs got stall=%b done=%b rd=%h exp 0/0/0", bus2.stallM, bus2.doneM, bus2.readdataM);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, n, to, e);
        total++; if (to || n != 2) begin bad++; $display("FAIL basic_store_timing got stalls=%0d timeout=%0d exp stalls=2", n, to); end
        acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, n, to, e);
        total++; if (to || n != 2) begin bad++; $display("FAIL basic_load_timing got stalls=%0d timeout=%0d exp stalls=2", n, to); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_load_data got=%h exp=deadbeef", rd); end
        idle2();
    endtask

    task automatic test_lanes();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, rd, n, to, e);
        acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'hDEAABEEF) begin bad++; $display("FAIL lane_byte2 got=%h exp=deaabeef", rd); end
        acc(1'b0, 1'b1, 32'h10, 32'h00001234, 4'b0011, rd, n, to, e);
        acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'hDEAA1234) begin bad++; $display("FAIL lane_half0 got=%h exp=deaa1234", rd); end
        acc(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, n, to, e);
        total++; if (to || n != 2) begin bad++; $display("FAIL lane_amp0_done got stalls=%0d timeout=%0d exp stalls=2", n, to); end
        acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'hDEAA1234) begin bad++; $display("FAIL lane_amp0_keep got=%h exp=deaa1234", rd); end
        idle2();
    endtask

    task automatic test_oor();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, n, to, e);
        acc(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, n, to, e);
        total++; if (to || n != 2) begin bad++; $display("FAIL oor_store_timing got stalls=%0d timeout=%0d exp stalls=2", n, to); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_err_early got=%b exp=0", e); end
        total++; if (bus2.errM !== 1'b1) begin bad++; $display("FAIL oor_err_set got=%b exp=1", bus2.errM); end
        acc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL oor_alias_word got=%h exp=a5a5a5a5", rd); end
        acc(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'hDEAA1234) begin bad++; $display("FAIL oor_other_word got=%h exp=deaa1234", rd); end
        acc(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, n, to, e);
        total++; if (to || n != 2 || rd !== 32'h0) begin bad++; $display("FAIL oor_load got=%h stalls=%0d exp data=0 stalls=2", rd, n); end
        total++; if (bus2.errM !== 1'b1) begin bad++; $display("FAIL oor_err_sticky got=%b exp=1", bus2.errM); end
        idle2();
    endtask

    task automatic test_abort();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, n, to, e);
        idle2();
        bus2.memwriteM  = 1'b1;
        bus2.aluoutM    = 32'h20;
        bus2.writedataM = 32'hFFFFFFFF;
        bus2.ampM       = 4'hF;
        @(negedge clk);
        total++; if (bus2.stallM !== 1'b1) begin bad++; $display("FAIL abort_first_stall got=%b exp=1", bus2.stallM); end
        @(posedge clk); #1;
        bus2.memwriteM = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (bus2.doneM !== 1'b0 || bus2.stallM !== 1'b0) begin
                bad++; $display("FAIL abort_quiet cycle=%0d got done=%b stall=%b exp 0/0", c, bus2.doneM, bus2.stallM);
            end
            @(posedge clk); #1;
        end
        acc(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, n, to, e);
        total++; if (to || n != 2 || rd !== 32'h0BADF00D) begin bad++; $display("FAIL abort_word got=%h stalls=%0d exp=0badf00d stalls=2", rd, n); end
        idle2();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, n, to, e);
        idle2();
        bus2.memwriteM  = 1'b1;
        bus2.aluoutM    = 32'h30;
        bus2.writedataM = 32'h0;
        bus2.ampM       = 4'hF;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (bus2.stallM !== 1'b0) begin bad++; $display("FAIL rstwait_stall got=%b exp=0", bus2.stallM); end
        @(posedge clk);
        @(posedge clk); #1;
        bus2.memwriteM = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (bus2.errM !== 1'b0) begin bad++; $display("FAIL rstwait_err_clear got=%b exp=0", bus2.errM); end
        @(posedge clk); #1;
        acc(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rd, n, to, e);
        total++; if (to || n != 2) begin bad++; $display("FAIL rstwait_next_timing got stalls=%0d timeout=%0d exp stalls=2", n, to); end
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL rstwait_word got=%h exp=cafef00d", rd); end
        idle2();
    endtask

    task automatic test_zero_wait();
        bus0.memwriteM  = 1'b1;
        bus0.aluoutM    = 32'h40;
        bus0.writedataM = 32'h11111111;
        bus0.ampM       = 4'hF;
        @(negedge clk);
        total++; if (bus0.stallM !== 1'b0 || bus0.doneM !== 1'b1) begin
            bad++; $display("FAIL zw_store got stall=%b done=%b exp 0/1", bus0.stallM, bus0.doneM);
        end
        @(posedge clk); #1;
        bus0.memwriteM = 1'b0;
        bus0.memreadM  = 1'b1;
        bus0.ampM      = 4'h0;
        @(negedge clk);
        total++; if (bus0.stallM !== 1'b0 || bus0.doneM !== 1'b1) begin
            bad++; $display("FAIL zw_load got stall=%b done=%b exp 0/1", bus0.stallM, bus0.doneM);
        end
        total++; if (bus0.readdataM !== 32'h11111111) begin bad++; $display("FAIL zw_data got=%h exp=11111111", bus0.readdataM); end
        @(posedge clk); #1;
        bus0.memreadM = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_both();
        logic [31:0] rd; int n; bit to; logic e;
        acc(1'b0, 1'b1, 32'h50, 32'h5, 4'hF, rd, n, to, e);
        acc(1'b1, 1'b1, 32'h50, 32'h9, 4'hF, rd, n, to, e);
        total++; if (to || rd !== 32'h5) begin bad++; $display("FAIL both_old_word got=%h exp=5", rd); end
        acc(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, rd, n, to, e);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL both_new_word got=%h exp=9", rd); end
        idle2();
    endtask

    task automatic test_random();
        logic [31:0] rd; int n; bit to; logic e;
        logic [31:0] d; logic [3:0] m; int k; int op; logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            acc(1'b0, 1'b1, 32'h100 + 32'(4 * i), d, 4'hF, rd, n, to, e);
            mdl[64 + i] = d;
        end
        for (int t = 0; t < 60; t++) begin
            k  = $urandom_range(0, 15);
            op = $urandom_range(0, 2);
            d  = $urandom;
            m  = 4'($urandom_range(0, 15));
            acc(op != 1, op != 0, 32'h100 + 32'(4 * k) + 32'($urandom_range(0, 3)), d, m, rd, n, to, e);
            exp = mdl[64 + k];
            total++; if (to || n != 2 || rd !== exp) begin
                bad++; $display("FAIL rand_%0d op=%0d got=%h stalls=%0d exp=%h stalls=2", t, op, rd, n, exp);
            end
            if (op != 0) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) mdl[64 + k][8*b +: 8] = d[8*b +: 8];
                end
            end
            if ($urandom_range(0, 3) == 0) idle2();
        end
        idle2();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lanes();
        test_oor();
        test_abort();
        test_reset_mid_wait();
        test_zero_wait();
        test_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
